// File: rtl/sys_defs.sv
// Shared types and constants for the ALU functional unit and its result queue.
// Entry fields are sized for the widest legal datapath and tag.
package sys_defs;

    localparam int XLEN_MAX  = 64;
    localparam int TAG_MAX_W = 16;

    localparam logic [31:0] ALU_DEFAULT_RESULT = 32'hfacebeec;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } ALU_FUNC;

    typedef struct packed {
        logic [XLEN_MAX-1:0]  v;
        logic [XLEN_MAX-1:0]  branch_loc;
        logic [TAG_MAX_W-1:0] rob_tag;
        logic                 take_branch;
    } FU_QUEUE_ENTRY;

endpackage

// File: rtl/alu_branch_unit.sv
// Combinational ALU plus branch-condition evaluation.
// The ALU result doubles as the branch target.
import sys_defs::*;

module alu_branch_unit #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    input  ALU_FUNC         alu_func,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      br_funct3,
    input  logic            cond_branch,
    input  logic            uncond_branch,
    input  logic [XLEN-1:0] npc,
    output logic [XLEN-1:0] alu_result,
    output logic            take_branch,
    output logic [XLEN-1:0] result_v
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    logic           cond;

    assign shamt = opb[SHW-1:0];

    always_comb begin
        alu_result = '0;
        case (alu_func)
            ALU_ADD:  alu_result = opa + opb;
            ALU_SUB:  alu_result = opa - opb;
            ALU_AND:  alu_result = opa & opb;
            ALU_OR:   alu_result = opa | opb;
            ALU_XOR:  alu_result = opa ^ opb;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}},
                                    $signed(opa) < $signed(opb)};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, opa < opb};
            ALU_SLL:  alu_result = opa << shamt;
            ALU_SRL:  alu_result = opa >> shamt;
            ALU_SRA:  alu_result = $signed(opa) >>> shamt;
            default:  alu_result = XLEN'(ALU_DEFAULT_RESULT);
        endcase
    end

    // 010 and 011 are not branch encodings and must never fire
    always_comb begin
        cond = 1'b0;
        case (br_funct3)
            BR_EQ:   cond = (rs1 == rs2);
            BR_NE:   cond = (rs1 != rs2);
            BR_LT:   cond = ($signed(rs1) <  $signed(rs2));
            BR_GE:   cond = ($signed(rs1) >= $signed(rs2));
            BR_LTU:  cond = (rs1 <  rs2);
            BR_GEU:  cond = (rs1 >= rs2);
            default: cond = 1'b0;
        endcase
    end

    assign take_branch = (cond_branch && cond) || uncond_branch;
    assign result_v    = take_branch ? npc : alu_result;

endmodule

// File: rtl/alu_fu_queue.sv
// ALU functional unit with an in-order result queue feeding the CDB.
// Head entry drives the outputs; squash and reset empty the queue.
import sys_defs::*;

module alu_fu_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [XLEN-1:0]          opa,
    input  logic [XLEN-1:0]          opb,
    input  ALU_FUNC                  alu_func,
    input  logic [XLEN-1:0]          rs1,
    input  logic [XLEN-1:0]          rs2,
    input  logic [2:0]               br_funct3,
    input  logic                     cond_branch,
    input  logic                     uncond_branch,
    input  logic [XLEN-1:0]          npc,
    input  logic [TAG_W-1:0]         rob_tag,
    input  logic                     ack,
    output logic                     out_done,
    output logic [XLEN-1:0]          out_v,
    output logic [XLEN-1:0]          out_branch_loc,
    output logic [TAG_W-1:0]         out_rob_tag,
    output logic                     out_take_branch,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    FU_QUEUE_ENTRY    mem_q [DEPTH];

    logic [XLEN-1:0]  alu_res;
    logic [XLEN-1:0]  res_v;
    logic             res_take;
    FU_QUEUE_ENTRY    new_entry;
    FU_QUEUE_ENTRY    head;
    logic             push;
    logic             pop;

    alu_branch_unit #(
        .XLEN(XLEN)
    ) u_alu (
        .opa          (opa),
        .opb          (opb),
        .alu_func     (alu_func),
        .rs1          (rs1),
        .rs2          (rs2),
        .br_funct3    (br_funct3),
        .cond_branch  (cond_branch),
        .uncond_branch(uncond_branch),
        .npc          (npc),
        .alu_result   (alu_res),
        .take_branch  (res_take),
        .result_v     (res_v)
    );

    // Ready depends only on registered occupancy and squash, never on ack
    assign issue_ready = (count_q < CW'(DEPTH)) && !squash;
    assign push        = issue_valid && issue_ready;
    assign pop         = ack && out_done && !squash;

    always_comb begin
        new_entry             = '0;
        new_entry.v           = XLEN_MAX'(res_v);
        new_entry.branch_loc  = XLEN_MAX'(alu_res);
        new_entry.rob_tag     = TAG_MAX_W'(rob_tag);
        new_entry.take_branch = res_take;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
        end else begin
            if (push) begin
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + PW'(1);
            end
            if (pop) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload is deliberately left unreset; valid bits guard it
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem_q[tail_q] <= new_entry;
        end
    end

    assign head     = mem_q[head_q];
    assign out_done = (count_q != '0) && valid_q[head_q];
    assign count    = count_q;

    assign out_v           = out_done ? head.v[XLEN-1:0] : '0;
    assign out_branch_loc  = out_done ? head.branch_loc[XLEN-1:0] : '0;
    assign out_rob_tag     = out_done ? head.rob_tag[TAG_W-1:0] : '0;
    assign out_take_branch = out_done && head.take_branch;

    logic unused_hi;
    assign unused_hi = ^{head.v >> XLEN,
                         head.branch_loc >> XLEN,
                         head.rob_tag >> TAG_W};

endmodule

// File: doc/alu_fu_queue.md
ALU_FU_QUEUE -- requirements
Module: alu_fu_queue

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 4, result-queue entries; legal values are powers of two, 2..16.
REQ-003 Parameter TAG_W, default 5, ROB tag width.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 squash  in  1  branch-mispredict flush.
REQ-007 issue_valid  in  1  issue request from the RS.
REQ-008 issue_ready  out  1  FU can accept an issue this cycle.
REQ-009 opa, opb  in  XLEN  pre-selected ALU operands.
REQ-010 alu_func  in  ALU_FUNC  operation select.
REQ-011 rs1, rs2  in  XLEN  branch-compare operands.
REQ-012 br_funct3  in  3  branch condition.
REQ-013 cond_branch, uncond_branch  in  1 each  branch type.
REQ-014 npc  in  XLEN  PC+4.
REQ-015 rob_tag  in  TAG_W  destination ROB tag.
REQ-016 ack  in  1  CDB accepted the head result.
REQ-017 out_done  out  1  head entry valid.
REQ-018 out_v, out_branch_loc  out  XLEN each  head result value and branch target.
REQ-019 out_rob_tag  out  TAG_W  head tag.
REQ-020 out_take_branch  out  1  head branch-taken flag.
REQ-021 count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-022 Accept = issue_valid && issue_ready, with issue_ready = (count < DEPTH) && !squash; issue_ready SHALL have no combinational path from ack.
REQ-023 ALU ops: ADD, SUB, AND, OR, XOR, SLT (signed), SLTU, SLL, SRL, SRA; shift amount = opb[$clog2(XLEN)-1:0]; an undefined func yields XLEN'(32'hfacebeec), zero-extended.
REQ-024 Branch condition by br_funct3: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; 010 and 011 SHALL evaluate false.
REQ-025 take = (cond_branch && cond) || uncond_branch; v = take ? npc : alu_result; branch_loc = alu_result.
REQ-026 An accepted entry SHALL be written at the tail on the same edge; it SHALL appear on out_* no earlier than the following cycle (latency 1).
REQ-027 Outputs are driven from the head entry; out_done = (count != 0); all out_* fields SHALL be 0 when count == 0.
REQ-028 ack while out_done SHALL pop the head on the edge; ack while empty SHALL be ignored.
REQ-029 Simultaneous push and pop SHALL leave count unchanged, and FIFO order SHALL be preserved.
REQ-030 Head and tail pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by count.
REQ-031 squash SHALL empty the queue and reset the pointers on the next edge; a same-cycle issue or ack has no effect.
REQ-032 Results SHALL retire in issue order; nothing is reordered or dropped except by squash or reset.

Reset
REQ-033 reset has priority over squash, ack and issue.
REQ-034 reset sets count, pointers and all entry valid bits to 0; out_* therefore read 0 in the first cycle after reset.
REQ-035 Entry payload storage is not reset; only valid and pointer state is.
REQ-036 reset asserted mid-stream discards all queued results.

Structure
REQ-037 ALU_FUNC, the FU_QUEUE_ENTRY struct (v, branch_loc, rob_tag, take_branch) and the 32'hfacebeec default constant belong in the shared sys_defs package.
REQ-038 Combinational compute lives in one sub-module, alu_branch_unit (ALU plus branch compare, parametrised by XLEN); the queue logic lives in alu_fu_queue.

Verification
REQ-039 Reset, then issue ADD 5+7 tag 3 with no ack: next cycle out_done=1, out_v=12, out_rob_tag=3, count=1; out_* hold until ack.
REQ-040 Issue 4 ops on consecutive cycles (DEPTH=4) with no ack: count=4 and issue_ready=0; a 5th issue is not accepted; one ack gives count=3 and issue_ready=1 the next cycle.
REQ-041 Sustained issue plus ack every cycle: count stays 1; tags 0,1,2,... retire in order across pointer wrap (at least 10 ops).
REQ-042 BNE rs1=1, rs2=2, cond_branch=1, npc=0x104, opa=0x100, opb=0x20: out_take_branch=1, out_v=0x104, out_branch_loc=0x120; the BEQ variant gives take=0, out_v=0x120.
REQ-043 XLEN=64: SRA with opa=0x8000_0000_0000_0000, opb=63 gives all-ones; undefined func gives 0x0000_0000_FACE_BEEC.
REQ-044 Queue holding 3 entries, assert squash together with issue_valid and ack: next cycle count=0, out_done=0; a reset asserted mid-stream also yields count=0.
